breakout_key_ctrl: RTL

Parametrised multi-channel key front end. It replaces the fixed three-key debouncer in the breakout design. Each channel:
- synchronises a raw push-button input;
- debounces it;
- produces a clean level, single-cycle press and release pulses, and an optional auto-repeat pulse.

It sits between the board buttons and breakout_fsm / MoveBall_logic. It runs in the sys_clk domain.

---
 rtl/breakout_key_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/breakout_key_ctrl.sv
// breakout_key_ctrl: multi-channel push-button front end.
// Per channel: 2-flop sync, debounce, press/release pulses, auto-repeat.
module breakout_key_ctrl #(
    parameter int                  NUM_KEYS      = 3,
    parameter int                  DEBOUNCE_TIME = 10000,
    parameter int                  REPEAT_DELAY  = 25000000,
    parameter int                  REPEAT_PERIOD = 5000000,
    parameter int                  CNT_W         = 25,
    parameter bit                  ACTIVE_LOW    = 1'b1,
    parameter logic [NUM_KEYS-1:0] REPEAT_EN     = {NUM_KEYS{1'b1}}
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    input  logic                repeat_gate,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic [NUM_KEYS-1:0] key_event
);

    typedef enum logic [1:0] {
        RP_IDLE   = 2'd0,
        RP_DELAY  = 2'd1,
        RP_REPEAT = 2'd2
    } rp_state_e;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TIME - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic             IDLE_RAW = ACTIVE_LOW;

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_ch
            logic             r_sync1;
            logic             r_sync2;
            logic             w_pressed;
            logic [CNT_W-1:0] r_db_cnt;
            logic [CNT_W-1:0] w_db_nxt;
            logic             w_flip;
            logic             w_rise;
            logic             w_fall;
            logic             r_level;
            logic             r_press;
            logic             r_release;
            logic             r_repeat;
            logic             r_event;
            logic             w_en;
            rp_state_e        r_state;
            rp_state_e        w_state_nxt;
            logic [CNT_W-1:0] r_rp_cnt;
            logic [CNT_W-1:0] w_rp_nxt;
            logic             w_rep;

            assign w_pressed = r_sync2 ^ ACTIVE_LOW;
            assign w_rise    = w_flip & w_pressed;
            assign w_fall    = w_flip & ~w_pressed;
            assign w_en      = REPEAT_EN[g];

            // two-flop synchroniser, idles at the released raw level
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_sync1 <= IDLE_RAW;
                    r_sync2 <= IDLE_RAW;
                end else begin
                    r_sync1 <= key_raw[g];
                    r_sync2 <= r_sync1;
                end
            end

            // debounce: count consecutive cycles of disagreement
            always_comb begin
                w_db_nxt = r_db_cnt;
                w_flip   = 1'b0;
                if (w_pressed == r_level) begin
                    w_db_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_flip   = 1'b1;
                    w_db_nxt = '0;
                end else if (r_db_cnt != CNT_MAX) begin
                    w_db_nxt = r_db_cnt + CNT_ONE;
                end
            end

            // repeat FSM: next state, counter and repeat pulse
            always_comb begin
                w_state_nxt = r_state;
                w_rp_nxt    = r_rp_cnt;
                w_rep       = 1'b0;
                if (!w_en || !repeat_gate || w_fall) begin
                    w_state_nxt = RP_IDLE;
                    w_rp_nxt    = '0;
                end else begin
                    unique case (r_state)
                        RP_IDLE: begin
                            w_rp_nxt = '0;
                            if (w_rise) begin
                                w_state_nxt = RP_DELAY;
                            end
                        end
                        RP_DELAY: begin
                            if (!r_level) begin
                                w_state_nxt = RP_IDLE;
                                w_rp_nxt    = '0;
                            end else if (r_rp_cnt == RD_LAST) begin
                                w_rep       = 1'b1;
                                w_rp_nxt    = '0;
                                w_state_nxt = RP_REPEAT;
                            end else if (r_rp_cnt != CNT_MAX) begin
                                w_rp_nxt = r_rp_cnt + CNT_ONE;
                            end
                        end
                        RP_REPEAT: begin
                            if (!r_level) begin
                                w_state_nxt = RP_IDLE;
                                w_rp_nxt    = '0;
                            end else if (r_rp_cnt == RP_LAST) begin
                                w_rep    = 1'b1;
                                w_rp_nxt = '0;
                            end else if (r_rp_cnt != CNT_MAX) begin
                                w_rp_nxt = r_rp_cnt + CNT_ONE;
                            end
                        end
                        default: begin
                            w_state_nxt = RP_IDLE;
                            w_rp_nxt    = '0;
                        end
                    endcase
                end
            end

            // registered level, pulses and counters
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_db_cnt  <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                    r_repeat  <= 1'b0;
                    r_event   <= 1'b0;
                    r_state   <= RP_IDLE;
                    r_rp_cnt  <= '0;
                end else begin
                    r_db_cnt  <= w_db_nxt;
                    r_level   <= r_level ^ w_flip;
                    r_press   <= w_rise;
                    r_release <= w_fall;
                    r_repeat  <= w_rep;
                    r_event   <= w_rise | w_rep;
                    r_state   <= w_state_nxt;
                    r_rp_cnt  <= w_rp_nxt;
                end
            end

            assign key_level[g]   = r_level;
            assign key_press[g]   = r_press;
            assign key_release[g] = r_release;
            assign key_repeat[g]  = r_repeat;
            assign key_event[g]   = r_event;
        end
    endgenerate

endmodule
